// File: rtl/fm_discriminator.sv
// rtl/fm_discriminator.sv - conjugate-product FM discriminator feeding the sample averager
//
// Computes y[n] = I[n-1]*Q[n] - Q[n-1]*I[n], arithmetic-shifted right by SHIFT
// and reduced to WIDTH bits. One output per accepted I/Q pair, except for the
// priming pair after reset or after start_i drops. Latency: accept edge k,
// valid_o high after edge k+2.
//
// Build option: FM_DISC_SAT_EN - when defined the shifted result saturates to
// the signed WIDTH-bit range; otherwise the low WIDTH bits are kept (wrap).
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous reset, active low
//   start_i  - enable; samples are accepted only while high
//   valid_i  - I/Q sample strobe
//   i_i      - in-phase sample, signed WIDTH
//   q_i      - quadrature sample, signed WIDTH
//   data_o   - discriminator output, signed WIDTH; holds between strobes
//   valid_o  - one-cycle strobe qualifying data_o

module fm_discriminator #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] i_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  localparam int PW = 2 * WIDTH;

  logic                 accept;
  logic [WIDTH-1:0]     i_d;
  logic [WIDTH-1:0]     q_d;
  logic                 primed;

  logic signed [PW-1:0] i_d_x;
  logic signed [PW-1:0] q_d_x;
  logic signed [PW-1:0] i_x;
  logic signed [PW-1:0] q_x;
  logic signed [PW-1:0] p1_c;
  logic signed [PW-1:0] p2_c;

  logic signed [PW-1:0] p1;
  logic signed [PW-1:0] p2;
  logic                 s1_valid;

  logic signed [PW:0]   diff_c;
  logic signed [PW:0]   diff;
  logic                 s2_valid;

  logic signed [PW:0]   sh_c;
  logic [WIDTH-1:0]     out_c;

  assign accept = start_i & valid_i;

  // Operands are sign-extended to the full product width so the multiply is
  // done at 2*WIDTH bits; the -2^(W-1) * -2^(W-1) corner still fits.
  assign i_d_x = {{WIDTH{i_d[WIDTH-1]}}, i_d};
  assign q_d_x = {{WIDTH{q_d[WIDTH-1]}}, q_d};
  assign i_x   = {{WIDTH{i_i[WIDTH-1]}}, i_i};
  assign q_x   = {{WIDTH{q_i[WIDTH-1]}}, q_i};
  assign p1_c  = i_d_x * q_x;
  assign p2_c  = q_d_x * i_x;

  // One extra bit makes the difference of two full-range products exact.
  assign diff_c = {p1[PW-1], p1} - {p2[PW-1], p2};
  assign sh_c   = diff >>> SHIFT;

`ifdef FM_DISC_SAT_EN
  logic sh_in_range;

  // In range when every bit above the output sign bit matches it.
  assign sh_in_range = (&sh_c[PW:WIDTH-1]) | ~(|sh_c[PW:WIDTH-1]);

  always_comb begin
    out_c = sh_c[WIDTH-1:0];
    if (!sh_in_range) begin
      out_c = sh_c[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_sh_hi;

  assign unused_sh_hi = ^sh_c[PW:WIDTH];
  assign out_c        = sh_c[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_d      <= '0;
      q_d      <= '0;
      primed   <= 1'b0;
      p1       <= '0;
      p2       <= '0;
      s1_valid <= 1'b0;
      diff     <= '0;
      s2_valid <= 1'b0;
      data_o   <= '0;
      valid_o  <= 1'b0;
    end else begin
      if (accept) begin
        i_d <= i_i;
        q_d <= q_i;
        p1  <= p1_c;
        p2  <= p2_c;
      end

      // Any cycle with start_i low forgets history, so the next accepted
      // sample after resume only primes.
      if (!start_i) begin
        primed <= 1'b0;
      end else if (valid_i) begin
        primed <= 1'b1;
      end

      // Stages already holding results keep draining while start_i is low.
      s1_valid <= accept & primed;

      diff     <= diff_c;
      s2_valid <= s1_valid;

      valid_o  <= s2_valid;
      if (s2_valid) begin
        data_o <= out_c;
      end
    end
  end

endmodule

// File: doc/fm_discriminator.md
# fm_discriminator

- Conjugate-product FM discriminator: y[n] = I[n-1]·Q[n] − Q[n-1]·I[n], arithmetically scaled back to WIDTH bits.
- Sits directly upstream of the 128-sample averaging stage and drives its `data_i` / `start_i`.
- Accepts one baseband I/Q pair per strobe; emits one frequency sample per accepted pair, except the priming pair.

## Interface

Parameters:
- `WIDTH`, default 16: width of I/Q inputs and of `data_o` (signed two's complement).
- `SHIFT`, default 15: arithmetic right shift applied to the product difference.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start_i`, input, 1: enable; samples are accepted only while high.
- `valid_i`, input, 1: I/Q sample strobe.
- `i_i`, input, WIDTH: in-phase sample, signed.
- `q_i`, input, WIDTH: quadrature sample, signed.
- `data_o`, output, WIDTH: discriminator output, signed; feeds the averager.
- `valid_o`, output, 1: one-cycle strobe qualifying `data_o`.

## Operation

- **Accept:** a sample is accepted at a rising edge where `start_i && valid_i`. There is no backpressure.
- **History registers:** `i_d` and `q_d` load `i_i` and `q_i` on every accepted sample.
- **Primed flag:**
  - Cleared by reset.
  - Cleared on any edge where `start_i` is low.
  - Set by the first accepted sample.
  - The first accepted sample after reset, or after `start_i` falls, only loads history and produces no output.
- **Pipeline** (one register per stage, valid bit travels alongside):
  - S1, at the accept edge: `p1 = i_d·q_i` and `p2 = q_d·i_i`, each 2·WIDTH signed. Valid = accept && primed.
  - S2: `diff = p1 − p2`, 2·WIDTH+1 signed (no overflow possible).
  - S3: `sh = diff >>> SHIFT` (arithmetic), reduced to WIDTH bits per Configuration. Loads `data_o` and drives `valid_o`.
- **`start_i` low:**
  - New samples are ignored.
  - Results already in S1/S2 still drain and emit `valid_o`.
- **Outputs:**
  - `data_o` holds its last value when `valid_o` is low.
  - `valid_o` is high for exactly one cycle per output.
- **Corner operand:** −2^(WIDTH−1)·−2^(WIDTH−1) = 2^(2·WIDTH−2) must be representable. It is, in 2·WIDTH signed.

## Timing

- **Reset values:** `data_o` = 0, `valid_o` = 0, `i_d` = `q_d` = 0, primed = 0, all pipeline valid bits = 0.
- **Reset assertion:** effective immediately (asynchronous). In-flight results are discarded and never emitted.
- **Latency:** sample accepted at edge k produces `valid_o` high after edge k+2, for one cycle.
- **Throughput:** one sample per clock. Back-to-back `valid_i` yields back-to-back `valid_o` with the same gap pattern, delayed by 2 edges.
- **Simultaneous events:**
  - `start_i` falling on the same edge as `valid_i`: no accept.
  - `start_i` rising with `valid_i`: that sample primes.

## Configuration

- **Macro:** `FM_DISC_SAT_EN`
- **Defined:** `sh` saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Undefined:** `data_o` is the low WIDTH bits of `sh` (two's-complement wrap).
- **Unaffected:** latency and handshake are identical in both builds.

## Test plan

1. **Reset:** hold `rst`=0 for 10 cycles with random inputs toggling -> `data_o`=0 and `valid_o`=0 throughout. Assert `rst`=0 mid-stream -> `valid_o` drops immediately and no stale output appears after release.
2. **Positive rotation:** `start_i`=1, samples (16384,0) then (0,16384) -> no output for the first sample. `valid_o` after edge k+2 of the second sample with `data_o`=8192.
3. **Negative rotation:** samples (0,16384) then (16384,0) -> single output `data_o`=−8192.
4. **Overflow:** samples (32767,−32767) then (32767,32767) -> diff=2147352578 and `sh`=65532. With `FM_DISC_SAT_EN`, `data_o`=32767. Without it, `data_o`=−4.
5. **Streaming:** 8 accepted samples on consecutive cycles, then 8 with `valid_i` every other cycle -> 7 back-to-back `valid_o` pulses, then pulses every other cycle. Values must match a bit-exact reference model.
6. **Restart:** drop `start_i` for 1 cycle immediately after accepting a sample, then resume -> in-flight results still emit. The first sample after resume produces no output; the second produces the correct value using only post-resume history.
